// File: rtl/cordic_rot_arbiter_if.sv
// ----------------------------------------------------------------------------
// cordic_rot_arbiter_if
// Request/response bundle between NUM_CH requesters and cordic_rot_arbiter.
//
// Handshake: a sample on channel i transfers in the cycle where
// req_valid[i] & req_ready[i] are both high. A requester keeps req_x/req_y
// stable while req_valid[i]=1 and req_ready[i]=0. rsp_valid is a one-cycle,
// one-hot strobe. It has no ready, so the requester must take the result in
// that cycle.
//
// Signals:
//   req_valid  NUM_CH             per-channel request valid
//   req_ready  NUM_CH             per-channel accept (one-hot or zero)
//   req_x      NUM_CH*DATA_WIDTH  x of channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_y      NUM_CH*DATA_WIDTH  y, packed like req_x
//   rsp_valid  NUM_CH             one-hot result strobe
//   rsp_rho    DATA_WIDTH         result modulus
//   rsp_theta  DATA_WIDTH         result angle
//
// Modports:
//   master  requester side
//   slave   arbiter side
// ----------------------------------------------------------------------------
interface cordic_rot_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] req_x;
    logic [NUM_CH*DATA_WIDTH-1:0] req_y;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]        rsp_rho;
    logic [DATA_WIDTH-1:0]        rsp_theta;

    modport master (
        output req_valid, req_x, req_y,
        input  req_ready, rsp_valid, rsp_rho, rsp_theta
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output req_ready, rsp_valid, rsp_rho, rsp_theta
    );
endinterface

// File: rtl/cordic_rot_arbiter.sv
// ----------------------------------------------------------------------------
// cordic_rot_arbiter
// Shares one pipelined CORDIC rotation unit (rho/theta) among NUM_CH
// requesters. After reset, all requesters are held off until the CORDIC ROM
// has loaded. After that, one sample is granted per cycle in round-robin
// order and is registered onto the CORDIC inputs. The CORDIC has no valid
// signal, so each issued sample is tracked by a {valid, ch} tag. The tag
// travels down a shift register that matches the CORDIC latency, which lets
// each result be routed back to its requester.
//
// Ports:
//   sys_clk       in   clock
//   sys_rst_n     in   asynchronous active-low reset
//   rif           slave  request/response bundle (cordic_rot_arbiter_if)
//   cordic_src_x  out  DATA_WIDTH  registered x to CORDIC
//   cordic_src_y  out  DATA_WIDTH  registered y to CORDIC
//   cordic_rho    in   DATA_WIDTH  CORDIC modulus
//   cordic_theta  in   DATA_WIDTH  CORDIC angle
//   warm_done     out  high once warm-up has completed
//   inflight      out  samples issued whose result has not yet been returned
//   dbg_state_o   out  current FSM state (0 = ST_WARM, 1 = ST_RUN)
// ----------------------------------------------------------------------------
module cordic_rot_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 4,
    parameter int ITERATION     = 8,
    parameter int ROM_LATENCY   = 2,
    parameter int WARMUP_CYCLES = ROM_LATENCY + ITERATION + 2,
    parameter int PIPE_LAT      = ITERATION + 2,
    parameter int INF_W         = $clog2(PIPE_LAT + 3)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    cordic_rot_arbiter_if.slave    rif,
    output logic [DATA_WIDTH-1:0]  cordic_src_x,
    output logic [DATA_WIDTH-1:0]  cordic_src_y,
    input  logic [DATA_WIDTH-1:0]  cordic_rho,
    input  logic [DATA_WIDTH-1:0]  cordic_theta,
    output logic                   warm_done,
    output logic [INF_W-1:0]       inflight,
    output logic                   dbg_state_o
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Warm-up FSM
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [CNT_W-1:0]   warm_cnt_q;
    logic               warm_done_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_WARM;
            warm_cnt_q  <= '0;
            warm_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WARM: begin
                    warm_cnt_q <= warm_cnt_q + CNT_W'(1);
                    if (warm_cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
                        state_q     <= ST_RUN;
                        warm_done_q <= 1'b1;
                    end
                end
                default: begin
                    // ST_RUN is terminal; only reset leaves it.
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration. The search starts one channel past the
    // last grant, so the channel that was just served has lowest priority.
    // ------------------------------------------------------------------
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              accept;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        if (state_q == ST_RUN) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!accept && rif.req_valid[(int'(ptr_q) + k) % NUM_CH]) begin
                    accept    = 1'b1;
                    grant_idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
                end
            end
            if (accept) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    assign rif.req_ready = grant;
    assign ptr_d         = accept ? grant_idx : ptr_q;

    // ------------------------------------------------------------------
    // Issue stage, tag pipe and output stage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]              src_x_q, src_x_d;
    logic [DATA_WIDTH-1:0]              src_y_q, src_y_d;
    logic                               iss_vld_q;
    logic [CH_W-1:0]                    iss_ch_q;
    // Tag stage j is live in the same cycle as CORDIC pipeline stage j+1.
    // The last stage therefore lines up with cordic_rho/cordic_theta.
    logic [PIPE_LAT-1:0]                tag_vld_q;
    logic [PIPE_LAT-1:0][CH_W-1:0]      tag_ch_q;
    logic                               end_vld;
    logic [CH_W-1:0]                    end_ch;
    logic [NUM_CH-1:0]                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]              rsp_rho_q, rsp_rho_d;
    logic [DATA_WIDTH-1:0]              rsp_theta_q, rsp_theta_d;
    logic [INF_W-1:0]                   inflight_q, inflight_d;

    assign end_vld = tag_vld_q[PIPE_LAT-1];
    assign end_ch  = tag_ch_q[PIPE_LAT-1];

    always_comb begin
        src_x_d     = '0;
        src_y_d     = '0;
        if (accept) begin
            src_x_d = rif.req_x[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            src_y_d = rif.req_y[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end

        rsp_valid_d = '0;
        rsp_rho_d   = rsp_rho_q;
        rsp_theta_d = rsp_theta_q;
        if (end_vld) begin
            rsp_valid_d = NUM_CH'(1) << end_ch;
            rsp_rho_d   = cordic_rho;
            rsp_theta_d = cordic_theta;
        end

        // When an accept and a return happen in the same cycle, the count
        // is unchanged.
        inflight_d = inflight_q;
        case ({accept, |rsp_valid_q})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q       <= CH_W'(NUM_CH - 1);
            src_x_q     <= '0;
            src_y_q     <= '0;
            iss_vld_q   <= 1'b0;
            iss_ch_q    <= '0;
            tag_vld_q   <= '0;
            tag_ch_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rho_q   <= '0;
            rsp_theta_q <= '0;
            inflight_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            iss_vld_q   <= accept;
            iss_ch_q    <= grant_idx;
            tag_vld_q   <= {tag_vld_q[PIPE_LAT-2:0], iss_vld_q};
            tag_ch_q    <= {tag_ch_q[PIPE_LAT-2:0], iss_ch_q};
            rsp_valid_q <= rsp_valid_d;
            rsp_rho_q   <= rsp_rho_d;
            rsp_theta_q <= rsp_theta_d;
            inflight_q  <= inflight_d;
        end
    end

    assign cordic_src_x  = src_x_q;
    assign cordic_src_y  = src_y_q;
    assign rif.rsp_valid = rsp_valid_q;
    assign rif.rsp_rho   = rsp_rho_q;
    assign rif.rsp_theta = rsp_theta_q;
    assign warm_done     = warm_done_q;
    assign inflight      = inflight_q;
    assign dbg_state_o   = state_q;

endmodule
